// File: rtl/uncereal_if.sv
// Receive-side port bundle for uncereal: serial line in, RAM write port and status out.
// wr_en is a one-cycle write strobe with no ready/backpressure: the RAM must accept every strobe.
interface uncereal_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              serialIn;
  logic              addr_clr;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              frame_err;
  logic              busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [2:0]        dbg_state;

  modport slave (
    input  serialIn, addr_clr,
    output data_out, data_valid, frame_err, busy, wr_en, wr_addr, wr_data, dbg_state
  );

  modport master (
    output serialIn, addr_clr,
    input  data_out, data_valid, frame_err, busy, wr_en, wr_addr, wr_data, dbg_state
  );
endinterface

// File: rtl/uncereal.sv
// Serial-to-parallel receiver: start bit, DATA_W data bits MSB first, stop bit.
// Good words are written to RAM through an auto-incrementing address; bad stop bits are flagged.
module uncereal #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 8
) (
  input  logic      sysclk,
  input  logic      reset,
  uncereal_if.slave bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_sync1;
  logic              r_sync2;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIT_W-1:0]  r_bitn;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_ferr;
  logic              r_busy;
  logic [ADDR_W-1:0] r_addr;
  logic              w_sin;

  assign w_sin = r_sync2;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_sync1 <= bus.serialIn;
      r_sync2 <= r_sync1;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;

      // The address moves one edge after the write strobe; a clear always wins.
      if (bus.addr_clr) begin
        r_addr <= '0;
      end else if (r_valid) begin
        r_addr <= r_addr + ADDR_ONE;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_sin) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt <= '0;
            if (!w_sin) begin
              r_state <= S_DATA;
              r_bitn  <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_shift[DATA_W-2:0], w_sin};
            r_bitn  <= r_bitn + BIT_ONE;
            if (r_bitn == BIT_LAST) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (w_sin) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_ERR;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_ERR: begin
          // A line stuck low must return high before a new start bit can be seen.
          if (w_sin) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = r_data;
  assign bus.data_valid = r_valid;
  assign bus.frame_err  = r_ferr;
  assign bus.busy       = r_busy;
  assign bus.wr_en      = r_valid;
  assign bus.wr_addr    = r_addr;
  assign bus.wr_data    = r_data;
  assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_uncereal.sv
// Bench for uncereal: serial frames driven bit by bit, writes recorded and checked against
// a frame-level model (expected pulse cycle, data and address computed from frame rules).
module tb_uncereal;
  localparam int C  = 6;
  localparam int H  = C / 2;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int STOP_OFS  = 2 + H + (DW + 1) * C;
  localparam int FRAME_LEN = (DW + 2) * C;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   m_addr = 0;

  uncereal_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  uncereal #(.CLKS_PER_BIT(C), .DATA_W(DW), .ADDR_W(AW)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic          dv;
    logic          we;
    logic [DW-1:0] data;
    logic [DW-1:0] wdata;
    logic [AW-1:0] addr;
  } wev_t;

  wev_t          wr_q[$];
  logic [AW-1:0] nxt_q[$];
  int            ferr_q[$];
  logic          pend = 1'b0;
  logic [DW-1:0] exp_q[$];
  int            t0_q[$];

  // Recorder: cyc here is the number of the edge just before this negedge.
  always @(negedge sysclk) begin
    if (pend) nxt_q.push_back(bus.wr_addr);
    pend <= bus.data_valid | bus.wr_en;
    if (bus.data_valid || bus.wr_en)
      wr_q.push_back('{cyc, bus.data_valid, bus.wr_en, bus.data_out, bus.wr_data, bus.wr_addr});
    if (bus.frame_err) ferr_q.push_back(cyc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got %0d cycles, required finish", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic clear_rec();
    wr_q.delete();
    nxt_q.delete();
    ferr_q.delete();
  endtask

  task automatic idle(input int n);
    bus.serialIn = 1'b1;
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop, output int t0);
    t0 = cyc + 1;
    bus.serialIn = 1'b0;
    repeat (C) @(posedge sysclk);
    #1;
    for (int i = DW - 1; i >= 0; i--) begin
      bus.serialIn = d[i];
      repeat (C) @(posedge sysclk);
      #1;
    end
    bus.serialIn = stop;
    repeat (C) @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (bus.data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %h required 0", bus.data_out); end
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b required 0", bus.data_valid); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b required 0", bus.frame_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b required 0", bus.wr_en); end
    checks++; if (bus.wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %h required 0", bus.wr_addr); end
    checks++; if (bus.wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %h required 0", bus.wr_data); end
    reset = 1'b0;
    m_addr = 0;
    idle(2);
  endtask

  task automatic test_single();
    int t0;
    clear_rec();
    send_frame(16'hA55A, 1'b1, t0);
    idle(2 * C);
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d writes required 1", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      checks++; if (wr_q[0].cyc != t0 + STOP_OFS) begin errors++; $display("FAIL single_time: got edge %0d required %0d", wr_q[0].cyc, t0 + STOP_OFS); end
      checks++; if (wr_q[0].data !== 16'hA55A) begin errors++; $display("FAIL single_data: got %h required a55a", wr_q[0].data); end
      checks++; if (wr_q[0].wdata !== 16'hA55A) begin errors++; $display("FAIL single_wr_data: got %h required a55a", wr_q[0].wdata); end
      checks++; if (wr_q[0].we !== 1'b1 || wr_q[0].dv !== 1'b1) begin errors++; $display("FAIL single_strobes: got we=%b dv=%b required 1 1", wr_q[0].we, wr_q[0].dv); end
      checks++; if (wr_q[0].addr !== AW'(m_addr)) begin errors++; $display("FAIL single_addr: got %h required %h", wr_q[0].addr, AW'(m_addr)); end
    end
    m_addr = (m_addr + 1) % (1 << AW);
    if (nxt_q.size() >= 1) begin
      checks++; if (nxt_q[0] !== AW'(m_addr)) begin errors++; $display("FAIL single_addr_next: got %h required %h", nxt_q[0], AW'(m_addr)); end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b required 0", bus.busy); end
    checks++; if (ferr_q.size() != 0) begin errors++; $display("FAIL single_no_ferr: got %0d required 0", ferr_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d[3];
    int t0s[3];
    d[0] = 16'h0001; d[1] = 16'h8000; d[2] = 16'hFFFF;
    clear_rec();
    for (int i = 0; i < 3; i++) send_frame(d[i], 1'b1, t0s[i]);
    idle(2 * C);
    checks++; if (wr_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d writes required 3", wr_q.size()); end
    for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
      checks++; if (wr_q[i].cyc != t0s[i] + STOP_OFS) begin errors++; $display("FAIL b2b_time[%0d]: got %0d required %0d", i, wr_q[i].cyc, t0s[i] + STOP_OFS); end
      checks++; if (wr_q[i].data !== d[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h required %h", i, wr_q[i].data, d[i]); end
      checks++; if (wr_q[i].addr !== AW'(m_addr + i)) begin errors++; $display("FAIL b2b_addr[%0d]: got %h required %h", i, wr_q[i].addr, AW'(m_addr + i)); end
      if (i > 0) begin
        checks++; if (wr_q[i].cyc - wr_q[i-1].cyc != FRAME_LEN) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d required %0d", i, wr_q[i].cyc - wr_q[i-1].cyc, FRAME_LEN); end
      end
    end
    m_addr = (m_addr + 3) % (1 << AW);
  endtask

  task automatic test_glitch();
    clear_rec();
    bus.serialIn = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b required 1", bus.busy); end
    idle(3 * C);
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL glitch_no_write: got %0d required 0", wr_q.size()); end
    checks++; if (ferr_q.size() != 0) begin errors++; $display("FAIL glitch_no_ferr: got %0d required 0", ferr_q.size()); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b required 0", bus.busy); end
    checks++; if (bus.wr_addr !== AW'(m_addr)) begin errors++; $display("FAIL glitch_addr: got %h required %h", bus.wr_addr, AW'(m_addr)); end
  endtask

  task automatic test_frame_err();
    int t0;
    int t1;
    clear_rec();
    send_frame(16'h1234, 1'b0, t0);
    repeat (100) @(posedge sysclk);
    #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ferr_hold_busy: got %b required 1", bus.busy); end
    checks++; if (ferr_q.size() != 1) begin errors++; $display("FAIL ferr_count: got %0d required 1", ferr_q.size()); end
    if (ferr_q.size() >= 1) begin
      checks++; if (ferr_q[0] != t0 + STOP_OFS) begin errors++; $display("FAIL ferr_time: got %0d required %0d", ferr_q[0], t0 + STOP_OFS); end
    end
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL ferr_no_write: got %0d required 0", wr_q.size()); end
    idle(C);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ferr_release: got %b required 0", bus.busy); end
    send_frame(16'h5678, 1'b1, t1);
    idle(2 * C);
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL ferr_next_count: got %0d required 1", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      checks++; if (wr_q[0].data !== 16'h5678) begin errors++; $display("FAIL ferr_next_data: got %h required 5678", wr_q[0].data); end
      checks++; if (wr_q[0].addr !== AW'(m_addr)) begin errors++; $display("FAIL ferr_next_addr: got %h required %h", wr_q[0].addr, AW'(m_addr)); end
      checks++; if (wr_q[0].cyc != t1 + STOP_OFS) begin errors++; $display("FAIL ferr_next_time: got %0d required %0d", wr_q[0].cyc, t1 + STOP_OFS); end
    end
    checks++; if (ferr_q.size() != 1) begin errors++; $display("FAIL ferr_single_pulse: got %0d required 1", ferr_q.size()); end
    m_addr = (m_addr + 1) % (1 << AW);
  endtask

  // Clears the address, then fills RAM slots 0..254 with random words and random idle gaps.
  task automatic test_random_fill();
    int t0;
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    clear_rec();
    exp_q.delete();
    t0_q.delete();
    bus.addr_clr = 1'b1;
    @(posedge sysclk);
    #1;
    bus.addr_clr = 1'b0;
    m_addr = 0;
    checks++; if (bus.wr_addr !== '0) begin errors++; $display("FAIL fill_clr: got %h required 0", bus.wr_addr); end
    for (int n = 0; n < 255; n++) begin
      d = 16'($urandom);
      send_frame(d, 1'b1, t0);
      exp_q.push_back(d);
      t0_q.push_back(t0);
      idle($urandom_range(0, 2 * C));
    end
    idle(2 * C);
    checks++; if (wr_q.size() != 255) begin errors++; $display("FAIL fill_count: got %0d required 255", wr_q.size()); end
    for (int i = 0; i < wr_q.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      t0 = t0_q.pop_front();
      checks++; if (wr_q[i].data !== e) begin errors++; $display("FAIL fill_data[%0d]: got %h required %h", i, wr_q[i].data, e); end
      checks++; if (wr_q[i].addr !== AW'(m_addr)) begin errors++; $display("FAIL fill_addr[%0d]: got %h required %h", i, wr_q[i].addr, AW'(m_addr)); end
      checks++; if (wr_q[i].cyc != t0 + STOP_OFS) begin errors++; $display("FAIL fill_time[%0d]: got %0d required %0d", i, wr_q[i].cyc, t0 + STOP_OFS); end
      m_addr = (m_addr + 1) % (1 << AW);
    end
    checks++; if (bus.wr_addr !== AW'(m_addr)) begin errors++; $display("FAIL fill_final_addr: got %h required %h", bus.wr_addr, AW'(m_addr)); end
  endtask

  task automatic test_clr_on_write();
    int t0;
    int tp;
    clear_rec();
    tp = cyc + 1;
    fork
      send_frame(16'hBEEF, 1'b1, t0);
      begin
        while (cyc < tp + STOP_OFS) begin
          @(posedge sysclk);
          #1;
        end
        bus.addr_clr = 1'b1;
        @(posedge sysclk);
        #1;
        bus.addr_clr = 1'b0;
      end
    join
    idle(2 * C);
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL clr_count: got %0d required 1", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      checks++; if (wr_q[0].addr !== AW'(m_addr)) begin errors++; $display("FAIL clr_addr: got %h required %h", wr_q[0].addr, AW'(m_addr)); end
      checks++; if (wr_q[0].data !== 16'hBEEF) begin errors++; $display("FAIL clr_data: got %h required beef", wr_q[0].data); end
    end
    m_addr = 0;
    if (nxt_q.size() >= 1) begin
      checks++; if (nxt_q[0] !== AW'(m_addr)) begin errors++; $display("FAIL clr_addr_next: got %h required 00", nxt_q[0]); end
    end
    checks++; if (bus.wr_addr !== AW'(m_addr)) begin errors++; $display("FAIL clr_addr_hold: got %h required 00", bus.wr_addr); end
  endtask

  task automatic test_wrap();
    int t0;
    logic [DW-1:0] d;
    clear_rec();
    d = 16'($urandom);
    send_frame(d, 1'b1, t0);
    idle(2 * C);
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL wrap_count: got %0d required 1", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      checks++; if (wr_q[0].addr !== AW'(m_addr)) begin errors++; $display("FAIL wrap_addr: got %h required %h", wr_q[0].addr, AW'(m_addr)); end
      checks++; if (wr_q[0].data !== d) begin errors++; $display("FAIL wrap_data: got %h required %h", wr_q[0].data, d); end
    end
    m_addr = (m_addr + 1) % (1 << AW);
    checks++; if (bus.wr_addr !== AW'(m_addr)) begin errors++; $display("FAIL wrap_to_zero: got %h required %h", bus.wr_addr, AW'(m_addr)); end
  endtask

  task automatic test_mid_reset();
    int t0;
    int tp;
    send_frame(16'h3C3C, 1'b1, t0);
    idle(2 * C);
    m_addr = (m_addr + 1) % (1 << AW);
    clear_rec();
    tp = cyc + 1;
    fork
      send_frame(16'hA5FF, 1'b1, t0);
      begin
        while (cyc < tp + 8 * C + H - 1) begin
          @(posedge sysclk);
          #1;
        end
        reset = 1'b1;
        @(posedge sysclk);
        #1;
        reset = 1'b0;
        checks++; if (bus.data_out !== '0) begin errors++; $display("FAIL mid_reset_data_out: got %h required 0", bus.data_out); end
        checks++; if (bus.wr_addr !== '0) begin errors++; $display("FAIL mid_reset_wr_addr: got %h required 0", bus.wr_addr); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b required 0", bus.busy); end
        checks++; if (bus.wr_en !== 1'b0 || bus.data_valid !== 1'b0 || bus.frame_err !== 1'b0) begin errors++; $display("FAIL mid_reset_pulses: got we=%b dv=%b fe=%b required 0 0 0", bus.wr_en, bus.data_valid, bus.frame_err); end
      end
    join
    m_addr = 0;
    idle(2 * C);
    checks++; if (wr_q.size() != 0 || ferr_q.size() != 0) begin errors++; $display("FAIL mid_reset_discard: got %0d writes %0d errs required 0 0", wr_q.size(), ferr_q.size()); end
    send_frame(16'h0F0F, 1'b1, t0);
    idle(2 * C);
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL mid_reset_next_count: got %0d required 1", wr_q.size()); end
    if (wr_q.size() >= 1) begin
      checks++; if (wr_q[0].data !== 16'h0F0F) begin errors++; $display("FAIL mid_reset_next_data: got %h required 0f0f", wr_q[0].data); end
      checks++; if (wr_q[0].addr !== AW'(m_addr)) begin errors++; $display("FAIL mid_reset_next_addr: got %h required %h", wr_q[0].addr, AW'(m_addr)); end
      checks++; if (wr_q[0].cyc != t0 + STOP_OFS) begin errors++; $display("FAIL mid_reset_next_time: got %0d required %0d", wr_q[0].cyc, t0 + STOP_OFS); end
    end
  endtask

  initial begin
    bus.serialIn = 1'b1;
    bus.addr_clr = 1'b0;
    reset = 1'b1;
    repeat (4) @(posedge sysclk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_random_fill();
    test_clr_on_write();
    test_random_fill();
    test_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
